// File: rtl/regfile_mp_sb_pkg.sv
// Shared register-file definitions: bus-shape macros derived from XLEN/NREG
// and the package constants/helpers used by the register file and its scoreboard.
`ifndef YSYX_23060251_REG_DEFS
`define YSYX_23060251_REG_DEFS
`define YSYX_23060251_REG_NUM(nreg) (nreg)
`define YSYX_23060251_REG_BUS(xlen) [(xlen)-1:0]
`define YSYX_23060251_RS_BUS(nreg) [$clog2(nreg)-1:0]
`define YSYX_23060251_ZERO_REG 0
`endif

package regfile_mp_sb_pkg;

    localparam int unsigned ZERO_REG = `YSYX_23060251_ZERO_REG;

    // x0 is architecturally constant: it is never written, never pending, always reads 0.
    function automatic logic is_zero_reg(input int unsigned idx);
        return idx == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared at
// writeback, with per-read-port busy flags for RAW stall detection in decode.
module regfile_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int NR     = 2,
    parameter int NW     = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic [NW-1:0]    wen_i,
    input  logic [NW*AW-1:0] rd_i,
    input  logic [NR*AW-1:0] rs_i,
    output logic [NR-1:0]    busy_o,
    output logic [NREG-1:0]  pend_o
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_i && !is_zero_reg(32'(issue_rd_i))) begin
            w_set[issue_rd_i] = 1'b1;
        end
        for (int k = 0; k < NW; k++) begin
            if (wen_i[k]) begin
                w_clr[rd_i[k*AW +: AW]] = 1'b1;
            end
        end
    end

    // Set dominates clear: a newly issued producer supersedes the one retiring now.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_set | (r_pend & ~w_clr);
        end
    end

    always_comb begin
        busy_o = '0;
        for (int j = 0; j < NR; j++) begin
            busy_o[j] = r_pend[rs_i[j*AW +: AW]]
                        && !((BYPASS != 0) && w_clr[rs_i[j*AW +: AW]]);
        end
    end

    assign pend_o = r_pend;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port general-purpose register file with hardwired-zero x0, optional
// write-to-read bypass and an integrated pending-write scoreboard.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NR     = 2,
    parameter int NW     = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NW-1:0]      wen_i,
    input  logic [NW*AW-1:0]   rd_i,
    input  logic [NW*XLEN-1:0] wdata_i,
    input  logic [NR*AW-1:0]   rs_i,
    output logic [NR*XLEN-1:0] src_o,
    output logic [NR-1:0]      busy_o,
    input  logic               issue_i,
    input  logic [AW-1:0]      issue_rd_i,
    output logic [NREG-1:0]    pend_o
);

    logic `YSYX_23060251_REG_BUS(XLEN) r_regs    [`YSYX_23060251_REG_NUM(NREG)];
    logic `YSYX_23060251_REG_BUS(XLEN) w_wr_data [`YSYX_23060251_REG_NUM(NREG)];
    logic [NREG-1:0]                   w_wr_en;

    // Ports are scanned in ascending order so the highest-index writer wins a conflict.
    always_comb begin
        w_wr_en = '0;
        for (int r = 0; r < NREG; r++) begin
            w_wr_data[r] = '0;
        end
        for (int k = 0; k < NW; k++) begin
            if (wen_i[k] && !is_zero_reg(32'(rd_i[k*AW +: AW]))) begin
                w_wr_en[rd_i[k*AW +: AW]]   = 1'b1;
                w_wr_data[rd_i[k*AW +: AW]] = wdata_i[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_wr_en[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
            end
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_read
        logic [AW-1:0]                     w_rs;
        logic `YSYX_23060251_REG_BUS(XLEN) w_val;

        assign w_rs = rs_i[j*AW +: AW];

        always_comb begin
            w_val = '0;
            if (!is_zero_reg(32'(w_rs))) begin
                if ((BYPASS != 0) && w_wr_en[w_rs]) begin
                    w_val = w_wr_data[w_rs];
                end else begin
                    w_val = r_regs[w_rs];
                end
            end
        end

        assign src_o[j*XLEN +: XLEN] = w_val;
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NR     (NR),
        .NW     (NW),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .issue_i    (issue_i),
        .issue_rd_i (issue_rd_i),
        .wen_i      (wen_i),
        .rd_i       (rd_i),
        .rs_i       (rs_i),
        .busy_o     (busy_o),
        .pend_o     (pend_o)
    );

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised general-purpose register file for the core, successor to the single-write/two-read register array.
- Configurable width, register count, read-port count and write-port count; x0 is hardwired to zero.
- Optional write-to-read bypass.
- Integrated scoreboard of pending-write bits so decode can stall on RAW hazards without a separate unit.

Parameters:
- XLEN, 32, register data width.
- NREG, 32, number of architectural registers (16 for RV32E); power of two.
- AW, $clog2(NREG), register index width (derived; not overridden).
- NR, 2, number of read ports.
- NW, 1, number of write ports.
- BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the old value.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wen_i  in  NW  per-port write enable.
- rd_i  in  NW*AW  packed write indices; port k occupies bits [k*AW +: AW].
- wdata_i  in  NW*XLEN  packed write data.
- rs_i  in  NR*AW  packed read indices.
- src_o  out  NR*XLEN  packed read data, combinational.
- busy_o  out  NR  per-read-port scoreboard hit: source has an outstanding producer.
- issue_i  in  1  instruction issued that will write rd.
- issue_rd_i  in  AW  destination of the issuing instruction.
- pend_o  out  NREG  raw pending-bit vector, for debug/difftest.

Behaviour:
- Reset (asynchronous, rst_i=1): all registers = 0; all pending bits = 0. Hence src_o = 0, busy_o = 0, pend_o = 0 during and after reset until the first write.
- Write: on the rising edge, for each k with wen_i[k]=1 and rd_i[k]!=0, reg[rd_i[k]] <= wdata_i[k]. Register-file write latency is 1 cycle.
- Writes to x0 are discarded; reg[0] is never stored and always reads 0.
- Write conflict: when several ports target the same register in one cycle, the highest-index port wins. The write is deterministic, with no X.
- Read: src_o[j] = (rs_j==0) ? 0 : reg[rs_j]. Pure combinational, zero latency.
- Bypass (BYPASS=1): if any wen_i[k]=1 with rd_i[k]==rs_j!=0, src_o[j] = wdata_i of the highest-index matching port. With BYPASS=0, the old value is read and the new value is visible the next cycle.
- Scoreboard, per register r, at the rising edge:
  - set = issue_i && issue_rd_i==r && r!=0.
  - clr = any wen_i[k] && rd_i[k]==r.
  - pend[r] <= set ? 1 : (clr ? 0 : pend[r]).
  - Simultaneous set and clr on the same r: set wins, because a new producer supersedes the retiring one.
  - pend[0] is constantly 0.
- busy_o[j] = pend[rs_j] && !(BYPASS && clr(rs_j) this cycle). With BYPASS, a consumer may proceed in the writeback cycle.
- Issuing to an already-pending register leaves pend=1 (write-after-write); no counting. The first writeback clears it, so the pipeline must guarantee in-order writeback.
- Reset mid-operation: pending bits and data are cleared immediately, regardless of clock.
- Illegal index (>= NREG): not possible since NREG is a power of two.

Decomposition:
- Shared package/header: `ysyx_23060251_reg_bus`, `ysyx_23060251_rs_bus`, `ysyx_23060251_reg_num` macros, updated to be derived from XLEN/NREG. Add `ysyx_23060251_zero_reg` = 0.
- Sub-module `regfile_scoreboard`: holds the pending bits and computes set/clr and busy_o. It takes the same clk_i/rst_i plus the issue, writeback and read-index buses.
- The data array, write-priority logic and bypass muxes stay in the top module.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle after writing x5=0xDEADBEEF -> src_o for rs=5 reads 0 immediately; pend_o=0.
- Basic write/read: wen_i=1, rd=3, wdata=0x12345678; next cycle rs0=3 -> src_o[0]=0x12345678. Also write rd=0, data=0xFFFFFFFF -> rs=0 reads 0.
- Bypass: BYPASS=1, same-cycle write x7=0xA5A5A5A5 and read rs1=7 -> src_o[1]=0xA5A5A5A5. With BYPASS=0 -> old value, new value next cycle.
- Write conflict: NW=2, both ports write x9 (port0 0x1, port1 0x2) -> x9=0x2; bypassed read also shows 0x2.
- Scoreboard:
  - issue rd=4 -> next cycle busy_o=1 for rs=4.
  - Writeback x4 -> busy_o=0 in that same cycle (BYPASS=1) and pend[4]=0 after the edge.
  - issue rd=0 -> pend_o stays 0.
- Set/clr collision: pend[6]=1; in one cycle issue rd=6 and write back x6 -> pend[6] remains 1 after the edge; x6 holds the written data.
